xbar_shift_accum: RTL and testbench

// - Downstream of the crossbar MVM datapath. Consumes the per-column xbar_out_mem vector produced at each mvm_done.
// - Each mvm_done ends one input bit-slice. Slice results are shift-and-added into per-column accumulators.
// - After NUM_SLICES slices, the finished vector drains one column per cycle over a valid/ready stream toward the VFU/output memory.

---
 rtl/xbar_shift_accum.sv | 134 +++++++++++++
 tb/tb_xbar_shift_accum.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/xbar_shift_accum.sv
// Shift-and-add accumulator for crossbar bit-slice results, drained one column per cycle.
// Optional OUT_SAT_EN: saturate drained words instead of truncating.
module xbar_shift_accum #(
    parameter int XBAR_SIZE   = 16,
    parameter int IN_BITS     = 16,
    parameter int ACC_BITS    = 32,
    parameter int OUT_BITS    = 16,
    parameter int NUM_SLICES  = 4,
    parameter int SLICE_SHIFT = 4,
    parameter int FRAC_SHIFT  = 8,
    localparam int IDX_W = (XBAR_SIZE > 1) ? $clog2(XBAR_SIZE) : 1,
    localparam int SL_W  = (NUM_SLICES > 1) ? $clog2(NUM_SLICES) : 1
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic                               clear,
    input  logic                               mvm_done,
    input  logic [XBAR_SIZE-1:0][IN_BITS-1:0]  xbar_out_mem,
    output logic                               busy,
    output logic                               out_valid,
    input  logic                               out_ready,
    output logic [OUT_BITS-1:0]                out_data,
    output logic [IDX_W-1:0]                   out_idx,
    output logic                               out_last,
    output logic                               err_drop
);

    if (IN_BITS + (NUM_SLICES - 1) * SLICE_SHIFT > ACC_BITS) begin : g_acc_chk
        $error("xbar_shift_accum: ACC_BITS too narrow for shifted slices");
    end

    typedef enum logic {ACC, DRAIN} state_t;

    state_t                             state_q, state_d;
    logic [SL_W-1:0]                    slice_q, slice_d;
    logic [IDX_W-1:0]                   idx_q, idx_d;
    logic [XBAR_SIZE-1:0][ACC_BITS-1:0] acc_q, acc_d;
    logic                               err_q, err_d;
    logic                               done_q;
    logic                               ign_q;
    logic                               capture;
    logic                               hshake;
    int                                 shamt;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ACC;
            slice_q <= '0;
            idx_q   <= '0;
            acc_q   <= '0;
            err_q   <= 1'b0;
            done_q  <= 1'b0;
            ign_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            slice_q <= slice_d;
            idx_q   <= idx_d;
            acc_q   <= acc_d;
            err_q   <= err_d;
            done_q  <= mvm_done && !clear;
            // a pulse seen while busy must never be captured later in ACC
            ign_q   <= mvm_done && busy && !clear;
        end
    end

    always_comb begin
        state_d = state_q;
        slice_d = slice_q;
        idx_d   = idx_q;
        acc_d   = acc_q;
        err_d   = err_q;
        shamt   = int'(slice_q) * SLICE_SHIFT;
        capture = done_q && !ign_q && (state_q == ACC);
        hshake  = (state_q == DRAIN) && out_ready;
        if (clear) begin
            state_d = ACC;
            slice_d = '0;
            idx_d   = '0;
            acc_d   = '0;
            err_d   = 1'b0;
        end else begin
            if ((state_q == DRAIN) && (mvm_done || done_q)) begin
                err_d = 1'b1;
            end
            unique case (state_q)
                ACC: begin
                    if (capture) begin
                        for (int c = 0; c < XBAR_SIZE; c++) begin
                            acc_d[c] = acc_q[c]
                                     + (ACC_BITS'(xbar_out_mem[c]) << shamt);
                        end
                        if (slice_q == SL_W'(NUM_SLICES - 1)) begin
                            slice_d = '0;
                            idx_d   = '0;
                            state_d = DRAIN;
                        end else begin
                            slice_d = slice_q + SL_W'(1);
                        end
                    end
                end
                DRAIN: begin
                    if (hshake) begin
                        acc_d[idx_q] = '0;
                        idx_d        = idx_q + IDX_W'(1);
                        if (idx_q == IDX_W'(XBAR_SIZE - 1)) begin
                            idx_d   = '0;
                            state_d = ACC;
                        end
                    end
                end
                default: state_d = ACC;
            endcase
        end
    end

    always_comb begin
        busy      = (state_q == DRAIN);
        out_valid = busy;
        out_idx   = busy ? idx_q : '0;
        out_last  = busy && (idx_q == IDX_W'(XBAR_SIZE - 1));
        out_data  = '0;
        if (busy) begin
            out_data = OUT_BITS'(acc_q[idx_q] >> FRAC_SHIFT);
`ifdef OUT_SAT_EN
            if ((acc_q[idx_q] >> (FRAC_SHIFT + OUT_BITS)) != '0) begin
                out_data = '1;
            end
`endif
        end
    end

    assign err_drop = err_q;

endmodule

// File: tb/tb_xbar_shift_accum.sv
// Scoreboard bench for xbar_shift_accum: model accumulators, queue of drained words.
module tb_xbar_shift_accum;

    logic                  clk = 1'b0;
    logic                  reset = 1'b0;
    logic                  clear = 1'b0;
    logic                  mvm_done = 1'b0;
    logic [15:0][15:0]     xbar_out_mem = '0;
    logic                  busy;
    logic                  out_valid;
    logic                  out_ready = 1'b0;
    logic [15:0]           out_data;
    logic [3:0]            out_idx;
    logic                  out_last;
    logic                  err_drop;

    typedef struct packed {
        logic [15:0] data;
        logic [3:0]  idx;
        logic        last;
    } exp_t;

    exp_t        exp_q[$];
    logic [31:0] m_acc[16];
    int          m_sl = 0;
    int          n_chk = 0;
    int          n_pass = 0;

    xbar_shift_accum dut (
        .clk(clk), .reset(reset), .clear(clear), .mvm_done(mvm_done),
        .xbar_out_mem(xbar_out_mem), .busy(busy), .out_valid(out_valid),
        .out_ready(out_ready), .out_data(out_data), .out_idx(out_idx),
        .out_last(out_last), .err_drop(err_drop)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    function automatic logic [15:0] drain_val(input logic [31:0] a);
        logic [31:0] s;
        s = a >> 8;
`ifdef OUT_SAT_EN
        if (s > 32'h0000_FFFF) return 16'hFFFF;
`endif
        return s[15:0];
    endfunction

    task automatic do_slice(input logic [15:0][15:0] d);
        mvm_done = 1'b1;
        @(negedge clk);
        mvm_done = 1'b0;
        xbar_out_mem = d;
        if (m_sl == 3) chk("pre_busy", busy, 0);
        for (int c = 0; c < 16; c++) begin
            m_acc[c] = m_acc[c] + (32'(d[c]) << (m_sl * 4));
        end
        @(negedge clk);
        if (m_sl == 3) begin
            m_sl = 0;
            chk("lat_valid", out_valid, 1);
            for (int c = 0; c < 16; c++) begin
                exp_q.push_back('{drain_val(m_acc[c]), 4'(c), c == 15});
                m_acc[c] = '0;
            end
        end else begin
            m_sl++;
        end
    endtask

    task automatic drain(input logic [0:3] pat, input int stop_idx);
        int  cyc = 0;
        int  k = 0;
        bit  stopped = 0;
        exp_t e;
        while (exp_q.size() > 0 && cyc < 200) begin
            if (out_valid && int'(out_idx) == stop_idx) begin
                stopped = 1;
                break;
            end
            out_ready = pat[k % 4];
            k++;
            e = exp_q[0];
            chk("valid", out_valid, 1);
            chk("data", out_data, e.data);
            chk("idx", out_idx, e.idx);
            chk("last", out_last, e.last);
            if (out_valid && out_ready) void'(exp_q.pop_front());
            @(negedge clk);
            cyc++;
        end
        out_ready = 1'b0;
        if (stopped) chk("stop_idx", out_idx, stop_idx);
        else begin
            chk("drain_left", exp_q.size(), 0);
            chk("valid_drop", out_valid, 0);
        end
    endtask

    task automatic mvm_const(input logic [15:0][15:0] d);
        for (int s = 0; s < 4; s++) do_slice(d);
    endtask

    task automatic mvm_rand();
        logic [15:0][15:0] d;
        for (int s = 0; s < 4; s++) begin
            for (int c = 0; c < 16; c++) d[c] = 16'($urandom);
            do_slice(d);
        end
    endtask

    initial begin
        logic [15:0][15:0] d;
        for (int c = 0; c < 16; c++) m_acc[c] = '0;
        repeat (3) @(negedge clk);
        reset = 1'b1;
        repeat (10) @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_valid", out_valid, 0);
        chk("rst_data", out_data, 0);
        chk("rst_idx", out_idx, 0);
        chk("rst_last", out_last, 0);
        chk("rst_err", err_drop, 0);

        d = '0;
        d[0] = 16'd1;
        mvm_const(d);
        drain(4'b1111, -1);

        d = '1;
        mvm_const(d);
        drain(4'b1111, -1);

        mvm_rand();
        drain(4'b1001, -1);
        chk("err_clean", err_drop, 0);

        mvm_rand();
        out_ready = 1'b0;
        mvm_done = 1'b1;
        xbar_out_mem = '1;
        @(negedge clk);
        mvm_done = 1'b0;
        @(negedge clk);
        chk("err_set", err_drop, 1);
        drain(4'b1111, -1);
        mvm_rand();
        drain(4'b1101, -1);
        chk("err_sticky", err_drop, 1);

        mvm_rand();
        drain(4'b1111, 5);
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        exp_q.delete();
        chk("clr_busy", busy, 0);
        chk("clr_valid", out_valid, 0);
        chk("clr_err", err_drop, 0);
        repeat (3) @(negedge clk);
        chk("clr_idle", out_valid, 0);
        mvm_rand();
        drain(4'b1111, -1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
